stream_pair_join: RTL and testbench

STREAM_PAIR_JOIN -- requirements
Module: stream_pair_join

---
 rtl/stream_pair_join.sv | 259 +++++++++++++++++++++++++
 tb/tb_stream_pair_join.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pair_join.sv
// stream_pair_join: joins two valid/ready streams (A = network output,
// B = expected) beat-for-beat into one paired stream for the error stage,
// and checks the pairing for framing faults.
//
// Each input owns a small FIFO. A pair is emitted only when both FIFOs
// hold a beat, and both heads pop together. Frame starts (fst) are checked
// for alignment between the streams and for frame length.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   a_data/a_fst/a_vld    stream A input, a_rdy back-pressure out
//   b_data/b_fst/b_vld    stream B input, b_rdy back-pressure out
//   o_a_data/o_b_data     paired heads, o_fst = A head fst
//   o_vld/o_rdy           joined stream handshake
//   err_clr               clears the sticky error flags
//   sync_err/len_err      sticky fst-misalignment / frame-length errors
//   frame_cnt             frames emitted (wraps)

// Per-input FIFO with registered ready and registered head.
// Ports
//   i_push/i_data   write side (caller guarantees push only while o_rdy)
//   i_pop           read side (caller guarantees pop only while non-empty)
//   o_rdy           registered "not full"
//   o_ne_nxt_c      combinational "non-empty after this edge"
//   o_head          registered head entry
module spj_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_rdy,
  output logic             o_ne_nxt_c,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_rdy;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_nxt;

  // Next occupancy, read pointer and head entry.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_rd_ptr_nxt = r_rd_ptr;
    w_head_nxt   = r_head;
    if (i_push && !i_pop) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!i_push && i_pop) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
    if (i_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end
    // With exactly one entry left after the edge and a push in flight,
    // that entry is the incoming beat, which is not yet in r_mem.
    if (i_push && (w_cnt_nxt == CW'(1))) begin
      w_head_nxt = i_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Pointers, occupancy, ready and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_rdy    <= 1'b0;
      r_head   <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdy    <= (w_cnt_nxt != CW'(DEPTH));
      r_head   <= w_head_nxt;
    end
  end

  // Storage array; not reset, contents are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (!reset && i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_rdy      = r_rdy;
  assign o_ne_nxt_c = (w_cnt_nxt != '0);
  assign o_head     = r_head;

endmodule

module stream_pair_join #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FRAME_LEN = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_fst,
  input  logic             a_vld,
  output logic             a_rdy,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_fst,
  input  logic             b_vld,
  output logic             b_rdy,
  output logic [WIDTH-1:0] o_a_data,
  output logic [WIDTH-1:0] o_b_data,
  output logic             o_fst,
  output logic             o_vld,
  input  logic             o_rdy,
  input  logic             err_clr,
  output logic             sync_err,
  output logic             len_err,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned EW = WIDTH + 1;
  localparam int unsigned BW = 16;

  logic          w_a_rdy;
  logic          w_b_rdy;
  logic          w_a_ne_nxt;
  logic          w_b_ne_nxt;
  logic [EW-1:0] w_a_head;
  logic [EW-1:0] w_b_head;
  logic          w_a_push;
  logic          w_b_push;
  logic          w_pop;
  logic          w_head_fst_a;
  logic          w_head_fst_b;

  logic          r_o_vld;
  logic          r_sync_err;
  logic          r_len_err;
  logic [BW-1:0] r_frame_cnt;
  logic [BW-1:0] r_beat_idx;
  logic          r_have_frame;

  logic          w_sync_set;
  logic          w_len_set;
  logic          w_sync_nxt;
  logic          w_len_nxt;
  logic [BW-1:0] w_frame_cnt_nxt;
  logic [BW-1:0] w_beat_idx_nxt;
  logic          w_have_frame_nxt;

  // Handshakes: pushes gated by the registered ready, pops always paired.
  assign w_a_push     = a_vld & w_a_rdy;
  assign w_b_push     = b_vld & w_b_rdy;
  assign w_pop        = r_o_vld & o_rdy;
  assign w_head_fst_a = w_a_head[WIDTH];
  assign w_head_fst_b = w_b_head[WIDTH];

  spj_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_a_push),
    .i_data     ({a_fst, a_data}),
    .i_pop      (w_pop),
    .o_rdy      (w_a_rdy),
    .o_ne_nxt_c (w_a_ne_nxt),
    .o_head     (w_a_head)
  );

  spj_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_b_push),
    .i_data     ({b_fst, b_data}),
    .i_pop      (w_pop),
    .o_rdy      (w_b_rdy),
    .o_ne_nxt_c (w_b_ne_nxt),
    .o_head     (w_b_head)
  );

  // Framing checks evaluated on each paired pop.
  always_comb begin
    w_sync_set       = 1'b0;
    w_len_set        = 1'b0;
    w_frame_cnt_nxt  = r_frame_cnt;
    w_beat_idx_nxt   = r_beat_idx;
    w_have_frame_nxt = r_have_frame;
    if (w_pop) begin
      w_sync_set = (w_head_fst_a != w_head_fst_b);
      if (w_head_fst_a) begin
        // New frame: the one just closed must have had exactly FRAME_LEN beats.
        if (r_have_frame && (r_beat_idx != BW'(FRAME_LEN))) begin
          w_len_set = 1'b1;
        end
        w_beat_idx_nxt   = BW'(1);
        w_frame_cnt_nxt  = r_frame_cnt + BW'(1);
        w_have_frame_nxt = 1'b1;
      end else begin
        // A continuation beat after FRAME_LEN beats means the frame overran.
        if (r_have_frame && (r_beat_idx == BW'(FRAME_LEN))) begin
          w_len_set = 1'b1;
        end
        if (r_beat_idx != {BW{1'b1}}) begin
          w_beat_idx_nxt = r_beat_idx + BW'(1);
        end
      end
    end
    // A set condition takes priority over a clear in the same cycle.
    w_sync_nxt = w_sync_set | (r_sync_err & ~err_clr);
    w_len_nxt  = w_len_set  | (r_len_err  & ~err_clr);
  end

  // Output valid, error flags and frame bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_o_vld      <= 1'b0;
      r_sync_err   <= 1'b0;
      r_len_err    <= 1'b0;
      r_frame_cnt  <= '0;
      r_beat_idx   <= '0;
      r_have_frame <= 1'b0;
    end else begin
      r_o_vld      <= w_a_ne_nxt & w_b_ne_nxt;
      r_sync_err   <= w_sync_nxt;
      r_len_err    <= w_len_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_beat_idx   <= w_beat_idx_nxt;
      r_have_frame <= w_have_frame_nxt;
    end
  end

  assign a_rdy     = w_a_rdy;
  assign b_rdy     = w_b_rdy;
  assign o_vld     = r_o_vld;
  assign o_a_data  = w_a_head[WIDTH-1:0];
  assign o_b_data  = w_b_head[WIDTH-1:0];
  assign o_fst     = w_head_fst_a;
  assign sync_err  = r_sync_err;
  assign len_err   = r_len_err;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_stream_pair_join.sv
// Bench for stream_pair_join: queue-based reference model, one per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_stream_pair_join;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned FL = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  a_data, b_data;
  logic          a_fst, a_vld, a_rdy;
  logic          b_fst, b_vld, b_rdy;
  logic [W-1:0]  o_a_data, o_b_data;
  logic          o_fst, o_vld, o_rdy;
  logic          err_clr;
  logic          sync_err, len_err;
  logic [15:0]   frame_cnt;

  stream_pair_join #(.WIDTH(W), .DEPTH(D), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_data    (a_data),
    .a_fst     (a_fst),
    .a_vld     (a_vld),
    .a_rdy     (a_rdy),
    .b_data    (b_data),
    .b_fst     (b_fst),
    .b_vld     (b_vld),
    .b_rdy     (b_rdy),
    .o_a_data  (o_a_data),
    .o_b_data  (o_b_data),
    .o_fst     (o_fst),
    .o_vld     (o_vld),
    .o_rdy     (o_rdy),
    .err_clr   (err_clr),
    .sync_err  (sync_err),
    .len_err   (len_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Pending source beats and model FIFO contents, {fst, data}.
  logic [W:0] src_a[$], src_b[$], mqa[$], mqb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_push_a = 0;
  bit chk_en   = 0;

  // Model state.
  bit          m_in_rst  = 1;
  bit          m_sync    = 0;
  bit          m_len     = 0;
  bit          m_started = 0;
  int          m_cur     = 0;
  logic [15:0] m_frames  = '0;
  bit          m_ra, m_rb, m_vld, m_pop, m_fa, m_fb, m_sset, m_lset;

  // Stimulus knobs: valid probability (%) and o_rdy mode.
  int unsigned pa = 100, pb = 100;
  int          rmode = 0;  // 0 always 1, 1 toggle, 2 random, 3 always 0

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_beats(input bit to_b, input int n, input int fst_at);
    logic [W:0] beat;
    for (int i = 0; i < n; i++) begin
      beat = {(i == fst_at), W'($urandom)};
      if (to_b) src_b.push_back(beat);
      else      src_a.push_back(beat);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (src_a.size() == 0 && src_b.size() == 0 && (mqa.size() == 0 || mqb.size() == 0))
        done = 1;
    end
    check("drain_in_budget", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Reference model: FIFOs as queues, framing rules as plain beat counting.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        mqa.delete();
        mqb.delete();
        m_in_rst  = 1;
        m_sync    = 0;
        m_len     = 0;
        m_started = 0;
        m_cur     = 0;
        m_frames  = '0;
      end else begin
        m_ra  = !m_in_rst && mqa.size() < D;
        m_rb  = !m_in_rst && mqb.size() < D;
        m_vld = mqa.size() > 0 && mqb.size() > 0;
        m_pop = m_vld && o_rdy;
        m_sset = 0;
        m_lset = 0;
        if (m_pop) begin
          m_fa = mqa[0][W];
          m_fb = mqb[0][W];
          m_sset = (m_fa != m_fb);
          if (m_fa) begin
            if (m_started && m_cur != FL) m_lset = 1;
            m_cur = 1;
            m_frames = m_frames + 16'd1;
            m_started = 1;
          end else begin
            m_cur++;
            if (m_started && m_cur == FL + 1) m_lset = 1;
          end
          void'(mqa.pop_front());
          void'(mqb.pop_front());
          n_pops++;
        end
        m_sync = m_sset || (m_sync && !err_clr);
        m_len  = m_lset || (m_len && !err_clr);
        if (a_vld && m_ra) begin
          mqa.push_back({a_fst, a_data});
          if (src_a.size() > 0) void'(src_a.pop_front());
          n_push_a++;
        end
        if (b_vld && m_rb) begin
          mqb.push_back({b_fst, b_data});
          if (src_b.size() > 0) void'(src_b.pop_front());
        end
        m_in_rst = 0;
      end
    end
  end

  // Input driver: present source heads with random gaps; drive o_rdy.
  initial begin
    a_vld = 0; b_vld = 0; a_fst = 0; b_fst = 0;
    a_data = '0; b_data = '0; o_rdy = 1;
    forever begin
      @(negedge clk);
      if (src_a.size() > 0 && $urandom_range(99) < pa) begin
        a_vld = 1'b1;
        {a_fst, a_data} = src_a[0];
      end else begin
        a_vld = 1'b0;
      end
      if (src_b.size() > 0 && $urandom_range(99) < pb) begin
        b_vld = 1'b1;
        {b_fst, b_data} = src_b[0];
      end else begin
        b_vld = 1'b0;
      end
      case (rmode)
        0:       o_rdy = 1'b1;
        1:       o_rdy = ~o_rdy;
        2:       o_rdy = 1'($urandom_range(1));
        default: o_rdy = 1'b0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_rdy", 32'(a_rdy), 32'(!m_in_rst && mqa.size() < D));
      check("b_rdy", 32'(b_rdy), 32'(!m_in_rst && mqb.size() < D));
      check("o_vld", 32'(o_vld), 32'(mqa.size() > 0 && mqb.size() > 0));
      if (mqa.size() > 0 && mqb.size() > 0) begin
        check("o_a_data", o_a_data, mqa[0][W-1:0]);
        check("o_b_data", o_b_data, mqb[0][W-1:0]);
        check("o_fst", 32'(o_fst), 32'(mqa[0][W]));
      end
      check("sync_err", 32'(sync_err), 32'(m_sync));
      check("len_err", 32'(len_err), 32'(m_len));
      check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset   = 1'b1;
    err_clr = 1'b0;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    check("rst_a_rdy", 32'(a_rdy), 32'd0);
    check("rst_b_rdy", 32'(b_rdy), 32'd0);
    check("rst_o_vld", 32'(o_vld), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_errs", 32'({sync_err, len_err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_a_rdy", 32'(a_rdy), 32'd1);
    check("post_rst_b_rdy", 32'(b_rdy), 32'd1);

    // One aligned frame, continuous.
    base = n_pops;
    add_beats(0, FL, 0);
    add_beats(1, FL, 0);
    wait_idle(300);
    check("s1_pairs", 32'(n_pops - base), 32'd36);
    check("s1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("s1_errs", 32'({sync_err, len_err}), 32'd0);

    // A streams while B idle: only DEPTH beats accepted.
    base = n_push_a;
    add_beats(0, FL, 0);
    repeat (10) @(negedge clk);
    check("s2_a_accepted", 32'(n_push_a - base), 32'd4);
    check("s2_a_rdy_full", 32'(a_rdy), 32'd0);
    check("s2_o_vld_idle", 32'(o_vld), 32'd0);
    base = n_pops;
    add_beats(1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_pops != base) break;
    end
    check("s2_one_pair", 32'(n_pops - base), 32'd1);
    check("s2_a_rdy_after_pop", 32'(a_rdy), 32'd1);
    add_beats(1, FL - 1, -1);
    wait_idle(300);
    check("s2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Two frames with o_rdy toggling every cycle.
    rmode = 1;
    base = n_pops;
    add_beats(0, FL, 0); add_beats(0, FL, 0);
    add_beats(1, FL, 0); add_beats(1, FL, 0);
    wait_idle(1000);
    check("s3_pairs", 32'(n_pops - base), 32'd72);
    check("s3_frame_cnt", 32'(frame_cnt), 32'd4);

    // Random gaps and random back-pressure.
    rmode = 2;
    pa = $urandom_range(100, 30);
    pb = $urandom_range(100, 30);
    for (int f = 0; f < 3; f++) begin
      add_beats(0, FL, 0);
      add_beats(1, FL, 0);
    end
    wait_idle(3000);
    check("s4_frame_cnt", 32'(frame_cnt), 32'd7);
    check("s4_errs", 32'({sync_err, len_err}), 32'd0);
    pa = 100; pb = 100; rmode = 0;

    // B fst lands on beat 1 while A fst is on beat 0.
    add_beats(0, 1, 0);
    add_beats(1, 1, -1);
    wait_idle(50);
    check("s5_sync_set", 32'(sync_err), 32'd1);
    pulse_clr();
    check("s5_sync_clr", 32'(sync_err), 32'd0);
    add_beats(0, FL - 1, -1);
    add_beats(1, FL - 1, 0);
    wait_idle(300);
    check("s5_sync_again", 32'(sync_err), 32'd1);
    check("s5_len_ok", 32'(len_err), 32'd0);
    pulse_clr();

    // Short frame (35) then a new frame.
    do_reset();
    add_beats(0, FL - 1, 0); add_beats(0, FL, 0);
    add_beats(1, FL - 1, 0); add_beats(1, FL, 0);
    wait_idle(500);
    check("s6_len_short", 32'(len_err), 32'd1);
    check("s6_frame_cnt", 32'(frame_cnt), 32'd2);
    pulse_clr();
    check("s6_len_clr", 32'(len_err), 32'd0);
    // Long frame (37): overrun flagged on the 37th beat.
    add_beats(0, FL + 1, 0);
    add_beats(1, FL + 1, 0);
    wait_idle(300);
    check("s6_len_long", 32'(len_err), 32'd1);
    check("s6_frame_cnt3", 32'(frame_cnt), 32'd3);
    pulse_clr();

    // Reset with three beats buffered per FIFO.
    rmode = 3;
    add_beats(0, 3, 0);
    add_beats(1, 3, 0);
    repeat (8) @(negedge clk);
    check("s7_buffered_vld", 32'(o_vld), 32'd1);
    do_reset();
    check("s7_o_vld", 32'(o_vld), 32'd0);
    check("s7_frame_cnt", 32'(frame_cnt), 32'd0);
    check("s7_a_rdy", 32'(a_rdy), 32'd1);
    rmode = 0;
    base = n_pops;
    add_beats(0, FL, 0);
    add_beats(1, FL, 0);
    wait_idle(300);
    check("s7_pairs", 32'(n_pops - base), 32'd36);
    check("s7_frame_cnt_after", 32'(frame_cnt), 32'd1);
    check("s7_errs", 32'({sync_err, len_err}), 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
